maxnet_controller: RTL and testbench
====================================

// Module: maxnet_controller
// PURPOSE
//  Sequencing FSM for the Maxnet winner-take-all datapath. Loads the N input
//  activations into the neuron registers, then repeats iterations until at most
//  one neuron output is positive. Each iteration streams the N weight columns
//  into the per-neuron MACs, drains the MAC pipeline and writes back ReLU results.
//  Reports completion, the winner index and the iteration count. Stops early on
//  a tie (all outputs zero) or when an iteration-count timeout is reached.
// PARAMETERS
//  N         4    neuron count; weight matrix is N x N
//  MAC_LAT   2    cycles from the last mac_en to a valid MAC result
//  MAX_ITER  100  iteration limit before timeout
//  ITER_W    8    width of iter_count; must satisfy MAX_ITER < 2**ITER_W
//  IDX_W     $clog2(N)  localparam, width of sel and winner_idx
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       begin a run; sampled only in IDLE
//  nz_mask      in   N       from datapath: bit i = 1 when neuron i output > 0
//  ld_x         out  1       load neuron registers from X inputs (LOAD state)
//  mac_clr      out  1       clear all MAC accumulators
//  mac_en       out  1       accumulate x[sel]*W[sel][i] into each MAC i
//  sel          out  IDX_W   weight column / activation index being streamed
//  ld_en        out  1       write ReLU(MAC result) into neuron registers
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse when a run ends
//  winner_valid out  1       exactly one neuron was positive at the end
//  winner_idx   out  IDX_W   index of the winner; 0 when winner_valid = 0
//  timeout      out  1       run ended because MAX_ITER was reached
//  iter_count   out  ITER_W  number of completed update iterations
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. All outputs are 0, including iter_count,
//    winner_idx, winner_valid and timeout. Reset aborts any run in progress
//    immediately. No partial results are kept.
//  - States and transitions:
//    - IDLE: start=1 -> LOAD.
//    - LOAD: ld_x=1 for one cycle; iter_count<=0; winner_valid, timeout and
//      winner_idx are cleared. Next state is CHECK.
//    - CHECK: evaluate nz_mask (neuron registers are already updated).
//      - popcount==1 -> DONE with winner_valid<=1 and winner_idx<=index of the
//        set bit.
//      - popcount==0 -> DONE with winner_valid<=0.
//      - else if iter_count==MAX_ITER -> DONE with timeout<=1.
//      - else -> CLR.
//    - CLR: mac_clr=1 for one cycle; sel<=0. Next state is ACC.
//    - ACC: mac_en=1 for exactly N cycles; sel = 0,1,...,N-1 on successive
//      cycles. Next state is WAIT.
//    - WAIT: MAC_LAT cycles; mac_en=0. Next state is UPDATE.
//    - UPDATE: ld_en=1 for one cycle; iter_count<=iter_count+1. Next state is
//      CHECK.
//    - DONE: done=1 for one cycle. Next state is IDLE.
//  - Iteration length is 1+N+MAC_LAT+1+1 cycles, which is 9 with the defaults.
//  - Latency: start seen at edge t gives LOAD at t+1, the first CHECK at t+2,
//    and the earliest done at t+3.
//  - start is ignored outside IDLE. If start is held high through DONE, a new run
//    begins after one IDLE cycle.
//  - winner_valid, winner_idx, timeout and iter_count hold their values after
//    DONE until the next LOAD.
//  - sel is 0 whenever the state is not ACC. mac_en, mac_clr, ld_x and ld_en are
//    mutually exclusive.
//  - iter_count never wraps: the timeout check in CHECK bounds it at MAX_ITER.
// TESTING
//  1. Reset low for 3 cycles mid-ACC (sel=2), then release -> all outputs 0 and
//     state IDLE. The next start then runs a normal sequence.
//  2. Start with nz_mask=4'b0100 already at the first CHECK -> done on cycle
//     t+3; winner_valid=1, winner_idx=2, iter_count=0; mac_en never asserted.
//  3. nz_mask=1111 at CHECK 0, 0111 after iteration 1, 0011 after 2, 0001 after 3
//     -> done with winner_idx=0, iter_count=3. Each iteration shows sel sequence
//     0,1,2,3 and a 9-cycle spacing between ld_en pulses.
//  4. nz_mask=1111 then 0000 after iteration 1 -> done with winner_valid=0,
//     winner_idx=0, timeout=0, iter_count=1.
//  5. MAX_ITER=3, nz_mask stuck at 0011 -> done after the third UPDATE+CHECK with
//     timeout=1, iter_count=3, winner_valid=0.
//  6. start pulsed during ACC and WAIT -> no effect on state or counters. With
//     start held high through DONE, the next LOAD occurs 2 cycles after done.

Source files
------------

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the Maxnet winner-take-all datapath: loads activations, iterates
// CLR/ACC/WAIT/UPDATE until at most one neuron is positive, a tie, or the iteration limit.
module maxnet_controller #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAC_LAT  = 2,
  parameter int unsigned MAX_ITER = 100,
  parameter int unsigned ITER_W   = 8,
  localparam int unsigned IDX_W   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      nz_mask,
  output logic              ld_x,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [IDX_W-1:0]  sel,
  output logic              ld_en,
  output logic              busy,
  output logic              done,
  output logic              winner_valid,
  output logic [IDX_W-1:0]  winner_idx,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned WaitW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StCheck, StClr, StAcc, StWait, StUpdate, StDone
  } state_e;

  state_e            state_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic              ld_x_q, mac_clr_q, mac_en_q, ld_en_q, busy_q, done_q;
  logic              winner_valid_q, timeout_q;
  logic [IDX_W-1:0]  sel_q, winner_idx_q;
  logic [ITER_W-1:0] iter_q;

  // Population count and index of the highest set bit of nz_mask.
  logic [IDX_W:0]   pop;
  logic [IDX_W-1:0] set_idx;
  always_comb begin
    pop     = '0;
    set_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + (IDX_W + 1)'(nz_mask[i]);
      if (nz_mask[i]) set_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      ld_x_q         <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      ld_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      sel_q          <= '0;
      winner_idx_q   <= '0;
      iter_q         <= '0;
    end else begin
      // Strobes and sel are asserted only in the state that owns them.
      ld_x_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      ld_en_q   <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StLoad;
            ld_x_q         <= 1'b1;
            busy_q         <= 1'b1;
            iter_q         <= '0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
            timeout_q      <= 1'b0;
          end
        end
        StLoad: state_q <= StCheck;
        StCheck: begin
          if (pop == (IDX_W + 1)'(1)) begin
            state_q        <= StDone;
            done_q         <= 1'b1;
            winner_valid_q <= 1'b1;
            winner_idx_q   <= set_idx;
          end else if (pop == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (iter_q == ITER_W'(MAX_ITER)) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            state_q   <= StClr;
            mac_clr_q <= 1'b1;
          end
        end
        StClr: begin
          state_q  <= StAcc;
          mac_en_q <= 1'b1;
        end
        StAcc: begin
          if (sel_q != IDX_W'(N - 1)) begin
            mac_en_q <= 1'b1;
            sel_q    <= sel_q + 1'b1;
          end else if (MAC_LAT == 0) begin
            state_q <= StUpdate;
            ld_en_q <= 1'b1;
          end else begin
            state_q    <= StWait;
            wait_cnt_q <= '0;
          end
        end
        StWait: begin
          if (wait_cnt_q == WaitW'(MAC_LAT - 1)) begin
            state_q <= StUpdate;
            ld_en_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StUpdate: begin
          state_q <= StCheck;
          iter_q  <= iter_q + 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ld_x         = ld_x_q;
  assign mac_clr      = mac_clr_q;
  assign mac_en       = mac_en_q;
  assign sel          = sel_q;
  assign ld_en        = ld_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Randomized bench for maxnet_controller: a per-run mask schedule drives nz_mask and a
// simple iteration model predicts done timing, winner, timeout and iteration count.
module tb_maxnet_controller;

  localparam int unsigned N        = 4;
  localparam int unsigned MAC_LAT  = 2;
  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned ITER_W   = 8;
  localparam int unsigned ITER_LEN = 1 + N + MAC_LAT + 1 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] nz_mask;
  logic       ld_x, mac_clr, mac_en, ld_en, busy, done, winner_valid, timeout;
  logic [1:0] sel, winner_idx;
  logic [7:0] iter_count;

  int n_checks = 0;
  int n_errors = 0;

  maxnet_controller #(
    .N(N), .MAC_LAT(MAC_LAT), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nz_mask(nz_mask),
    .ld_x(ld_x), .mac_clr(mac_clr), .mac_en(mac_en), .sel(sel), .ld_en(ld_en),
    .busy(busy), .done(done), .winner_valid(winner_valid), .winner_idx(winner_idx),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] out_vec();
    return {ld_x, mac_clr, mac_en, sel, ld_en, busy, done, winner_valid, winner_idx,
            timeout, iter_count};
  endfunction

  // One complete run: masks[k] is what the datapath reports after k iterations.
  task automatic do_run(input logic [3:0] masks [4], input bit hold_start, input bit glitch);
    int k_exp, cyc, k, acc_pos, last_ld, macs, clrs, done_cyc;
    bit exp_wv, exp_to, bad_excl, bad_sel, bad_gap, bad_busy;
    logic [1:0] exp_idx;
    // Reference: walk the schedule by the stop rules.
    exp_wv = 0; exp_to = 0; exp_idx = 0; k_exp = 0;
    for (int j = 0; j < 4; j++) begin
      k_exp = j;
      if ($countones(masks[j]) == 1) begin
        exp_wv = 1;
        for (int b = 0; b < 4; b++) if (masks[j][b]) exp_idx = 2'(b);
        break;
      end
      if ($countones(masks[j]) == 0) break;
      if (j == int'(MAX_ITER)) begin exp_to = 1; break; end
    end
    k = 0; cyc = 0; acc_pos = 0; last_ld = -1; macs = 0; clrs = 0; done_cyc = -1;
    bad_excl = 0; bad_sel = 0; bad_gap = 0; bad_busy = 0;
    nz_mask = masks[0];
    start = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = glitch && (mac_en || mac_clr) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($countones({ld_x, mac_clr, mac_en, ld_en}) > 1) bad_excl = 1;
      if (!busy) bad_busy = 1;
      if (mac_clr) clrs++;
      if (mac_en) begin
        if (int'(sel) != acc_pos) bad_sel = 1;
        acc_pos = (acc_pos + 1) % N;
        macs++;
      end else if (sel != 0) begin
        bad_sel = 1;
      end
      if (ld_en) begin
        if (last_ld >= 0 && cyc - last_ld != ITER_LEN) bad_gap = 1;
        last_ld = cyc;
        k++;
        if (k < 4) nz_mask = masks[k];
      end
      if (done) done_cyc = cyc;
    end
    start = hold_start;
    check_eq("done_latency", done_cyc, 3 + ITER_LEN * k_exp);
    check_eq("winner_valid", winner_valid, exp_wv);
    check_eq("winner_idx", winner_idx, exp_idx);
    check_eq("timeout", timeout, exp_to);
    check_eq("iter_count", iter_count, k_exp);
    check_eq("mac_en_count", macs, N * k_exp);
    check_eq("mac_clr_count", clrs, k_exp);
    check_eq("ld_en_count", k, k_exp);
    check_eq("strobes_exclusive", bad_excl, 0);
    check_eq("sel_sequence", bad_sel, 0);
    check_eq("ld_en_spacing", bad_gap, 0);
    check_eq("busy_in_run", bad_busy, 0);
    @(negedge clk);
    check_eq("idle_after_done", {busy, done}, 2'b00);
    check_eq("results_held", {winner_valid, winner_idx, timeout, iter_count},
             {exp_wv, exp_idx, exp_to, 8'(k_exp)});
    if (hold_start) begin
      @(negedge clk);
      check_eq("reload_after_done", ld_x, 1'b1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 50) begin @(negedge clk); cyc++; end
      check_eq("second_run_done", done, 1'b1);
      @(negedge clk);
    end
  endtask

  logic [3:0] m [4];
  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; nz_mask = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", out_vec(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-ACC at sel==2.
    nz_mask = 4'b1111; start = 1'b1;
    cyc = 0;
    while (!(mac_en && sel == 2) && cyc < 30) begin @(negedge clk); start = 1'b0; cyc++; end
    check_eq("reached_acc_sel2", {mac_en, sel}, 3'b110);
    rst_n = 1'b0;
    #1 check_eq("async_reset", out_vec(), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", out_vec(), '0);

    m = '{4'b0100, 4'b0000, 4'b0000, 4'b0000}; do_run(m, 0, 0);
    m = '{4'b1111, 4'b0111, 4'b0011, 4'b0001}; do_run(m, 0, 0);
    m = '{4'b1111, 4'b0000, 4'b0000, 4'b0000}; do_run(m, 0, 0);
    m = '{4'b0011, 4'b0011, 4'b0011, 4'b0011}; do_run(m, 0, 0);
    m = '{4'b1111, 4'b0111, 4'b0011, 4'b0001}; do_run(m, 0, 1);
    m = '{4'b0100, 4'b0100, 4'b0100, 4'b0100}; do_run(m, 1, 0);

    for (int r = 0; r < 25; r++) begin
      for (int j = 0; j < 4; j++) m[j] = 4'($urandom_range(0, 15));
      do_run(m, 0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
